// File: rtl/mipi_tx_cmd_arbiter_pkg.sv
// Shared types and constants for the CSI-2 TX command arbiter.
// Holds the arbiter state encoding, the CSI-2 data-type codes used around the
// TX command port, and the short/long packet classification helper.
package mipi_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR_V = 3'd1,
    ST_HDR_A = 3'd2,
    ST_PAY_V = 3'd3,
    ST_PAY_A = 3'd4
  } arb_state_e;

  localparam logic [5:0] DT_FS     = 6'h00;
  localparam logic [5:0] DT_FE     = 6'h01;
  localparam logic [5:0] DT_LS     = 6'h02;
  localparam logic [5:0] DT_LE     = 6'h03;
  localparam logic [5:0] DT_NULL   = 6'h10;
  localparam logic [5:0] DT_BLANK  = 6'h11;
  localparam logic [5:0] DT_RGB888 = 6'h24;
  localparam logic [5:0] DT_RAW    = 6'h2A;

  // Data types from 0x10 upwards carry a payload after the header.
  localparam logic [5:0] LONG_PKT_MIN = 6'h10;

  // Aux queue entry: {data_type[5:0], byte_count[15:0]}.
  localparam int AUX_CMD_W = 22;

  function automatic logic is_long(input logic [5:0] dt);
    return (dt >= LONG_PKT_MIN);
  endfunction

endpackage

// File: rtl/mipi_tx_cmd_arbiter_aux_cmd_fifo.sv
// Aux command queue: synchronous FIFO with first-word-fall-through head.
// A push while full is dropped unless a pop happens in the same cycle, and a
// dropped push sets a sticky overflow flag; a new overflow beats a clear.
module aux_cmd_fifo
  import mipi_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 CLK_tx,
  input  logic                 RSTn,
  input  logic                 wr,
  input  logic [AUX_CMD_W-1:0] wr_data,
  input  logic                 rd,
  input  logic                 ovf_clr,
  output logic [AUX_CMD_W-1:0] head,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AUX_CMD_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 ovf_r;
  logic                 push_s;
  logic                 pop_s;

  assign full     = (count_r == CW'(DEPTH));
  assign empty    = (count_r == {CW{1'b0}});
  assign head     = mem_r[rd_ptr_r];
  assign overflow = ovf_r;
  assign pop_s    = rd && !empty;
  assign push_s   = wr && (!full || pop_s);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK_tx) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; pointer wrap relies on DEPTH being a power of two.
  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag; a dropped push in the clear cycle keeps it set.
  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn) begin
      ovf_r <= 1'b0;
    end else if (wr && full && !pop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

endmodule

// File: rtl/mipi_tx_cmd_arbiter.sv
// Two-requester arbiter for the CSI-2 TX controller command port.
// Video (line/frame timing generator) wins at every packet boundary; the aux
// queue is served when video is not requesting. A grant is held for header
// plus payload, and every new header is issued from IDLE.
// Optional macro MIPI_TX_ARB_STARVE_GUARD_EN adds a starvation counter that
// forces a waiting aux entry in after STARVE_LIMIT cycles.
module mipi_tx_cmd_arbiter
  import mipi_tx_pkg::*;
#(
  parameter int          AUX_DEPTH    = 4,
  parameter logic [15:0] STARVE_LIMIT = 16'd4096
) (
  input  logic        CLK_tx,
  input  logic        RSTn,
  input  logic [5:0]  vid_data_type,
  input  logic [15:0] vid_byte_count,
  input  logic        vid_req,
  output logic        vid_ack,
  output logic        vid_payload_en,
  output logic        vid_payload_en_last,
  input  logic        aux_wr,
  input  logic [5:0]  aux_wr_data_type,
  input  logic [15:0] aux_wr_byte_count,
  output logic        aux_full,
  output logic        aux_payload_en,
  output logic        aux_payload_en_last,
  output logic        aux_overflow,
  input  logic        aux_overflow_clr,
  output logic [5:0]  Tx_cmd_data_type,
  output logic [15:0] Tx_cmd_byte_count,
  output logic        Tx_cmd_req,
  input  logic        Tx_cmd_ack,
  input  logic        Tx_payload_en,
  input  logic        Tx_payload_en_last
);

  arb_state_e           state_r;
  logic [AUX_CMD_W-1:0] aux_head_s;
  logic                 aux_empty_s;
  logic                 aux_pop_s;
  logic                 starve_hit_s;

  // The head is consumed when the TX core accepts the aux header.
  assign aux_pop_s = (state_r == ST_HDR_A) && Tx_cmd_ack;

  aux_cmd_fifo #(
    .DEPTH (AUX_DEPTH)
  ) u_aux_fifo (
    .CLK_tx   (CLK_tx),
    .RSTn     (RSTn),
    .wr       (aux_wr),
    .wr_data  ({aux_wr_data_type, aux_wr_byte_count}),
    .rd       (aux_pop_s),
    .ovf_clr  (aux_overflow_clr),
    .head     (aux_head_s),
    .full     (aux_full),
    .empty    (aux_empty_s),
    .overflow (aux_overflow)
  );

`ifdef MIPI_TX_ARB_STARVE_GUARD_EN
  logic [15:0] starve_cnt_r;
  logic        aux_waiting_s;

  assign aux_waiting_s = !aux_empty_s && (state_r != ST_HDR_A) && (state_r != ST_PAY_A);
  assign starve_hit_s  = (starve_cnt_r >= STARVE_LIMIT);

  // Count cycles a pending aux entry waits outside its own grant.
  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn) begin
      starve_cnt_r <= 16'd0;
    end else if (aux_pop_s) begin
      starve_cnt_r <= 16'd0;
    end else if (aux_waiting_s && (starve_cnt_r < STARVE_LIMIT)) begin
      starve_cnt_r <= starve_cnt_r + 16'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  // Strict video priority: the limit only matters when the guard is built in.
  assign starve_hit_s = 1'b0 & (STARVE_LIMIT == 16'hFFFF);
`endif

  // Grant state machine: pick at IDLE, hold through header and payload.
  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (starve_hit_s && !aux_empty_s) begin
            state_r <= ST_HDR_A;
          end else if (vid_req) begin
            state_r <= ST_HDR_V;
          end else if (!aux_empty_s) begin
            state_r <= ST_HDR_A;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HDR_V: begin
          if (!vid_req) begin
            state_r <= ST_IDLE;
          end else if (Tx_cmd_ack) begin
            state_r <= is_long(vid_data_type) ? ST_PAY_V : ST_IDLE;
          end else begin
            state_r <= ST_HDR_V;
          end
        end
        ST_HDR_A: begin
          if (Tx_cmd_ack) begin
            state_r <= is_long(aux_head_s[21:16]) ? ST_PAY_A : ST_IDLE;
          end else begin
            state_r <= ST_HDR_A;
          end
        end
        ST_PAY_V, ST_PAY_A: begin
          if (Tx_payload_en_last) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Zero-latency routing of command fields, acks and payload strobes.
  always_comb begin
    Tx_cmd_req          = 1'b0;
    Tx_cmd_data_type    = 6'h00;
    Tx_cmd_byte_count   = 16'h0000;
    vid_ack             = 1'b0;
    vid_payload_en      = 1'b0;
    vid_payload_en_last = 1'b0;
    aux_payload_en      = 1'b0;
    aux_payload_en_last = 1'b0;
    case (state_r)
      ST_HDR_V: begin
        Tx_cmd_req        = vid_req;
        Tx_cmd_data_type  = vid_data_type;
        Tx_cmd_byte_count = vid_byte_count;
        vid_ack           = vid_req & Tx_cmd_ack;
      end
      ST_HDR_A: begin
        Tx_cmd_req        = 1'b1;
        Tx_cmd_data_type  = aux_head_s[21:16];
        Tx_cmd_byte_count = aux_head_s[15:0];
      end
      ST_PAY_V: begin
        vid_payload_en      = Tx_payload_en;
        vid_payload_en_last = Tx_payload_en_last;
      end
      ST_PAY_A: begin
        aux_payload_en      = Tx_payload_en;
        aux_payload_en_last = Tx_payload_en_last;
      end
      default: begin
        Tx_cmd_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mipi_tx_cmd_arbiter.sv
// Bench for mipi_tx_cmd_arbiter: a cycle table for the basic video/aux flows,
// hand sequences for long payloads, contention, overflow, withdrawal, reset and
// (with MIPI_TX_ARB_STARVE_GUARD_EN) starvation, then random traffic checked
// against a packet-level reference model.
module tb_mipi_tx_cmd_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 16;

  logic        CLK_tx;
  logic        RSTn;
  logic [5:0]  vid_data_type;
  logic [15:0] vid_byte_count;
  logic        vid_req;
  logic        vid_ack;
  logic        vid_payload_en;
  logic        vid_payload_en_last;
  logic        aux_wr;
  logic [5:0]  aux_wr_data_type;
  logic [15:0] aux_wr_byte_count;
  logic        aux_full;
  logic        aux_payload_en;
  logic        aux_payload_en_last;
  logic        aux_overflow;
  logic        aux_overflow_clr;
  logic [5:0]  Tx_cmd_data_type;
  logic [15:0] Tx_cmd_byte_count;
  logic        Tx_cmd_req;
  logic        Tx_cmd_ack;
  logic        Tx_payload_en;
  logic        Tx_payload_en_last;

  int n_vec = 0;
  int n_err = 0;

  mipi_tx_cmd_arbiter #(
    .AUX_DEPTH    (DEPTH),
    .STARVE_LIMIT (16'(LIMIT))
  ) dut (
    .CLK_tx              (CLK_tx),
    .RSTn                (RSTn),
    .vid_data_type       (vid_data_type),
    .vid_byte_count      (vid_byte_count),
    .vid_req             (vid_req),
    .vid_ack             (vid_ack),
    .vid_payload_en      (vid_payload_en),
    .vid_payload_en_last (vid_payload_en_last),
    .aux_wr              (aux_wr),
    .aux_wr_data_type    (aux_wr_data_type),
    .aux_wr_byte_count   (aux_wr_byte_count),
    .aux_full            (aux_full),
    .aux_payload_en      (aux_payload_en),
    .aux_payload_en_last (aux_payload_en_last),
    .aux_overflow        (aux_overflow),
    .aux_overflow_clr    (aux_overflow_clr),
    .Tx_cmd_data_type    (Tx_cmd_data_type),
    .Tx_cmd_byte_count   (Tx_cmd_byte_count),
    .Tx_cmd_req          (Tx_cmd_req),
    .Tx_cmd_ack          (Tx_cmd_ack),
    .Tx_payload_en       (Tx_payload_en),
    .Tx_payload_en_last  (Tx_payload_en_last)
  );

  initial CLK_tx = 1'b0;
  always #5 CLK_tx = ~CLK_tx;

  typedef struct {
    logic        vreq;
    logic [5:0]  vdt;
    logic        awr;
    logic [5:0]  adt;
    logic [15:0] abc;
    logic        ack;
    logic        pe;
    logic        last;
    logic [29:0] exp;
  } vec_t;

  vec_t tbl[18];

  // Reference model state: owner 0 none / 1 video / 2 aux, pay = in payload.
  int          m_owner;
  bit          m_pay;
  logic [21:0] m_q[$];
  bit          m_ovf;
  int          m_wait;

  // Packed view of every DUT output, in one fixed order.
  function automatic logic [29:0] dut_out();
    return {Tx_cmd_req, Tx_cmd_data_type, Tx_cmd_byte_count, vid_ack, vid_payload_en,
            vid_payload_en_last, aux_payload_en, aux_payload_en_last, aux_full, aux_overflow};
  endfunction

  // flags = {vid_ack, vid_pe, vid_pe_last, aux_pe, aux_pe_last, aux_full, aux_overflow}
  function automatic logic [29:0] ev(input logic req, input logic [5:0] dt,
                                     input logic [15:0] bc, input logic [6:0] flags);
    return {req, dt, bc, flags};
  endfunction

  function automatic vec_t mk(input logic vreq, input logic [5:0] vdt, input logic awr,
                              input logic [5:0] adt, input logic [15:0] abc, input logic ack,
                              input logic pe, input logic last, input logic [29:0] exp);
    vec_t v;
    v.vreq = vreq; v.vdt = vdt; v.awr = awr; v.adt = adt; v.abc = abc;
    v.ack = ack; v.pe = pe; v.last = last; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_zero();
    vid_req = 1'b0; vid_data_type = 6'h00; vid_byte_count = 16'h0000;
    aux_wr = 1'b0; aux_wr_data_type = 6'h00; aux_wr_byte_count = 16'h0000;
    aux_overflow_clr = 1'b0; Tx_cmd_ack = 1'b0; Tx_payload_en = 1'b0; Tx_payload_en_last = 1'b0;
  endtask

  task automatic do_reset();
    drive_zero();
    RSTn = 1'b0;
    #3;
    chk("reset_outputs", 32'(dut_out()), 32'd0);
    repeat (2) @(negedge CLK_tx);
    RSTn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] dts[4];
    logic [29:0] e;
    int vcnt, vlast, acnt, w, found, nv;
    logic [15:0] drain_bc[4];
    bit hdr_v, hdr_a, pop, starve;
    int qlen;

    RSTn = 1'b1;
    drive_zero();
    #2;
    do_reset();

    // ---------------- table: short video, long video, long aux ----------------
    tbl[0]  = mk(1'b0, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b0, 1'b0, ev(1'b0, 6'h00, 16'h0000, 7'b0000000));
    tbl[1]  = mk(1'b1, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b0, 1'b0, ev(1'b0, 6'h00, 16'h0000, 7'b0000000));
    tbl[2]  = mk(1'b1, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b0, 1'b0, ev(1'b1, 6'h00, 16'h0CA8, 7'b0000000));
    tbl[3]  = mk(1'b1, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b0, 1'b0, ev(1'b1, 6'h00, 16'h0CA8, 7'b0000000));
    tbl[4]  = mk(1'b1, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b0, 1'b0, ev(1'b1, 6'h00, 16'h0CA8, 7'b0000000));
    tbl[5]  = mk(1'b1, 6'h00, 1'b0, 6'h00, 16'd0, 1'b1, 1'b0, 1'b0, ev(1'b1, 6'h00, 16'h0CA8, 7'b1000000));
    tbl[6]  = mk(1'b1, 6'h24, 1'b0, 6'h00, 16'd0, 1'b0, 1'b0, 1'b0, ev(1'b0, 6'h00, 16'h0000, 7'b0000000));
    tbl[7]  = mk(1'b1, 6'h24, 1'b0, 6'h00, 16'd0, 1'b1, 1'b0, 1'b0, ev(1'b1, 6'h24, 16'h0CA8, 7'b1000000));
    tbl[8]  = mk(1'b0, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b1, 1'b0, ev(1'b0, 6'h00, 16'h0000, 7'b0100000));
    tbl[9]  = mk(1'b0, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b1, 1'b0, ev(1'b0, 6'h00, 16'h0000, 7'b0100000));
    tbl[10] = mk(1'b0, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b1, 1'b1, ev(1'b0, 6'h00, 16'h0000, 7'b0110000));
    tbl[11] = mk(1'b0, 6'h00, 1'b1, 6'h10, 16'd6, 1'b0, 1'b0, 1'b0, ev(1'b0, 6'h00, 16'h0000, 7'b0000000));
    tbl[12] = mk(1'b0, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b0, 1'b0, ev(1'b0, 6'h00, 16'h0000, 7'b0000000));
    tbl[13] = mk(1'b0, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b0, 1'b0, ev(1'b1, 6'h10, 16'h0006, 7'b0000000));
    tbl[14] = mk(1'b0, 6'h00, 1'b0, 6'h00, 16'd0, 1'b1, 1'b0, 1'b0, ev(1'b1, 6'h10, 16'h0006, 7'b0000000));
    tbl[15] = mk(1'b0, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b1, 1'b0, ev(1'b0, 6'h00, 16'h0000, 7'b0001000));
    tbl[16] = mk(1'b0, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b1, 1'b1, ev(1'b0, 6'h00, 16'h0000, 7'b0001100));
    tbl[17] = mk(1'b0, 6'h00, 1'b0, 6'h00, 16'd0, 1'b0, 1'b0, 1'b0, ev(1'b0, 6'h00, 16'h0000, 7'b0000000));

    for (int i = 0; i < 18; i++) begin
      @(negedge CLK_tx);
      vid_req = tbl[i].vreq; vid_data_type = tbl[i].vdt; vid_byte_count = 16'h0CA8;
      aux_wr = tbl[i].awr; aux_wr_data_type = tbl[i].adt; aux_wr_byte_count = tbl[i].abc;
      Tx_cmd_ack = tbl[i].ack; Tx_payload_en = tbl[i].pe; Tx_payload_en_last = tbl[i].last;
      #1;
      chk($sformatf("table[%0d]", i), 32'(dut_out()), 32'(tbl[i].exp));
    end

    // ---------------- long video packet, 3240 payload strobes ----------------
    do_reset();
    vid_req = 1'b1; vid_data_type = 6'h24; vid_byte_count = 16'h0CA8;
    @(negedge CLK_tx); #1;
    chk("long_hdr", {Tx_cmd_req, Tx_cmd_data_type, Tx_cmd_byte_count}, {1'b1, 6'h24, 16'h0CA8});
    Tx_cmd_ack = 1'b1;
    @(negedge CLK_tx);
    Tx_cmd_ack = 1'b0; vid_req = 1'b0;
    vcnt = 0; vlast = 0; acnt = 0;
    for (int i = 0; i < 3240; i++) begin
      Tx_payload_en = 1'b1; Tx_payload_en_last = (i == 3239);
      #1;
      vcnt += int'(vid_payload_en); vlast += int'(vid_payload_en_last);
      acnt += int'(aux_payload_en) + int'(aux_payload_en_last) + int'(Tx_cmd_req);
      @(negedge CLK_tx);
    end
    chk("long_vid_strobes", vcnt, 3240);
    chk("long_vid_last", vlast, 1);
    chk("long_no_aux_or_req", acnt, 0);
    Tx_payload_en = 1'b0; Tx_payload_en_last = 1'b0; vid_req = 1'b1; vid_data_type = 6'h00;
    #1;
    chk("long_back_idle", Tx_cmd_req, 0);
    @(negedge CLK_tx); #1;
    chk("long_next_hdr", Tx_cmd_req, 1);

    // ---------------- contention: video holds, one aux entry waits ----------------
    do_reset();
    aux_wr = 1'b1; aux_wr_data_type = 6'h02; aux_wr_byte_count = 16'h1234;
    vid_req = 1'b1; vid_data_type = 6'h24; vid_byte_count = 16'h0100;
    for (int p = 0; p < 2; p++) begin
      @(negedge CLK_tx);
      aux_wr = 1'b0;
      #1;
      chk("cont_vid_hdr", {Tx_cmd_req, Tx_cmd_data_type}, {1'b1, 6'h24});
      Tx_cmd_ack = 1'b1;
      @(negedge CLK_tx);
      Tx_cmd_ack = 1'b0; Tx_payload_en = 1'b1; Tx_payload_en_last = 1'b1;
      #1;
      chk("cont_vid_pay", {vid_payload_en_last, aux_payload_en, aux_payload_en_last}, 3'b100);
      @(negedge CLK_tx);
      Tx_payload_en = 1'b0; Tx_payload_en_last = 1'b0;
      if (p == 1) vid_req = 1'b0;
      #1;
      chk("cont_idle_gap", Tx_cmd_req, 0);
    end
    @(negedge CLK_tx); #1;
    chk("cont_aux_hdr", {Tx_cmd_req, Tx_cmd_data_type, Tx_cmd_byte_count}, {1'b1, 6'h02, 16'h1234});
    Tx_cmd_ack = 1'b1;
    @(negedge CLK_tx);
    Tx_cmd_ack = 1'b0;
    #1;
    chk("cont_aux_done", {Tx_cmd_req, aux_full, vid_ack}, 3'b000);

    // ---------------- overflow, clear priority, push+pop while full ----------------
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK_tx);
      aux_wr = 1'b1; aux_wr_data_type = 6'h01; aux_wr_byte_count = 16'(k);
    end
    @(negedge CLK_tx);
    aux_wr = 1'b0;
    #1;
    chk("ovf_full_set", {aux_full, aux_overflow}, 2'b11);
    @(negedge CLK_tx); #1;
    chk("ovf_sticky", aux_overflow, 1);
    aux_wr = 1'b1; aux_overflow_clr = 1'b1;
    @(negedge CLK_tx);
    aux_wr = 1'b0; aux_overflow_clr = 1'b0;
    #1;
    chk("ovf_set_beats_clr", aux_overflow, 1);
    aux_overflow_clr = 1'b1;
    @(negedge CLK_tx);
    aux_overflow_clr = 1'b0;
    #1;
    chk("ovf_cleared", aux_overflow, 0);
    chk("ovf_head", {Tx_cmd_req, Tx_cmd_byte_count}, {1'b1, 16'd1});
    Tx_cmd_ack = 1'b1; aux_wr = 1'b1; aux_wr_byte_count = 16'd6;
    @(negedge CLK_tx);
    Tx_cmd_ack = 1'b0; aux_wr = 1'b0;
    #1;
    chk("ovf_pushpop_full", {aux_full, aux_overflow}, 2'b10);
    drain_bc[0] = 16'd2; drain_bc[1] = 16'd3; drain_bc[2] = 16'd4; drain_bc[3] = 16'd6;
    for (int j = 0; j < 4; j++) begin
      w = 0;
      while (!Tx_cmd_req && w < 8) begin
        @(negedge CLK_tx); #1; w++;
      end
      chk($sformatf("drain_req[%0d]", j), Tx_cmd_req, 1);
      chk($sformatf("drain_bc[%0d]", j), Tx_cmd_byte_count, drain_bc[j]);
      Tx_cmd_ack = 1'b1;
      @(negedge CLK_tx);
      Tx_cmd_ack = 1'b0;
      #1;
    end
    w = 0;
    repeat (4) begin
      @(negedge CLK_tx); #1;
      w += int'(Tx_cmd_req) + int'(aux_full);
    end
    chk("drain_empty", w, 0);

    // ---------------- withdrawal in HDR_V, reset during PAY_V ----------------
    do_reset();
    vid_req = 1'b1; vid_data_type = 6'h24; vid_byte_count = 16'h0040;
    @(negedge CLK_tx); #1;
    chk("wd_hdr", Tx_cmd_req, 1);
    vid_req = 1'b0;
    #1;
    chk("wd_withdrawn", {Tx_cmd_req, vid_ack}, 2'b00);
    @(negedge CLK_tx);
    vid_req = 1'b1;
    #1;
    chk("wd_back_idle", Tx_cmd_req, 0);
    @(negedge CLK_tx);
    Tx_cmd_ack = 1'b1;
    #1;
    chk("wd_reissue_ack", vid_ack, 1);
    @(negedge CLK_tx);
    Tx_cmd_ack = 1'b0; vid_req = 1'b0; Tx_payload_en = 1'b1;
    #1;
    chk("rst_in_payload", vid_payload_en, 1);
    RSTn = 1'b0;
    #1;
    chk("rst_mid_packet", 32'(dut_out()), 32'd0);
    @(negedge CLK_tx);
    RSTn = 1'b1; Tx_payload_en = 1'b0;
    #1;
    chk("rst_released_idle", 32'(dut_out()), 32'd0);

`ifdef MIPI_TX_ARB_STARVE_GUARD_EN
    // ---------------- starvation guard: continuous short video ----------------
    do_reset();
    vid_req = 1'b1; vid_data_type = 6'h00; Tx_cmd_ack = 1'b1;
    aux_wr = 1'b1; aux_wr_data_type = 6'h02; aux_wr_byte_count = 16'h00AA;
    found = 0; nv = 0;
    for (int n = 1; n <= 40 && found == 0; n++) begin
      @(negedge CLK_tx);
      aux_wr = 1'b0;
      #1;
      if (Tx_cmd_req && Tx_cmd_data_type == 6'h02) found = n;
      else if (vid_ack) nv++;
    end
    chk("starve_grant_cycle", found, 19);
    chk("starve_video_acks", nv, 9);
`endif

    // ---------------- random traffic vs reference model ----------------
    do_reset();
    m_owner = 0; m_pay = 1'b0; m_q.delete(); m_ovf = 1'b0; m_wait = 0;
    dts[0] = 6'h00; dts[1] = 6'h02; dts[2] = 6'h10; dts[3] = 6'h24;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK_tx);
      vid_req = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      vid_data_type = dts[$urandom_range(0, 3)];
      vid_byte_count = 16'($urandom_range(0, 65535));
      aux_wr = ($urandom_range(0, 2) == 0);
      aux_wr_data_type = dts[$urandom_range(0, 3)];
      aux_wr_byte_count = 16'($urandom_range(0, 65535));
      aux_overflow_clr = ($urandom_range(0, 15) == 0);
      Tx_cmd_ack = ($urandom_range(0, 1) == 0);
      Tx_payload_en = ($urandom_range(0, 1) == 0);
      Tx_payload_en_last = ($urandom_range(0, 3) == 0);
      #1;
      qlen  = m_q.size();
      hdr_v = (m_owner == 1) && !m_pay;
      hdr_a = (m_owner == 2) && !m_pay;
      e = ev((hdr_v && vid_req) || hdr_a,
             hdr_v ? vid_data_type : (hdr_a ? m_q[0][21:16] : 6'h00),
             hdr_v ? vid_byte_count : (hdr_a ? m_q[0][15:0] : 16'h0000),
             {hdr_v && vid_req && Tx_cmd_ack,
              (m_owner == 1) && m_pay && Tx_payload_en,
              (m_owner == 1) && m_pay && Tx_payload_en_last,
              (m_owner == 2) && m_pay && Tx_payload_en,
              (m_owner == 2) && m_pay && Tx_payload_en_last,
              qlen == DEPTH, m_ovf});
      chk($sformatf("random[%0d]", i), 32'(dut_out()), 32'(e));

      // Advance the model across the coming clock edge.
      pop = hdr_a && Tx_cmd_ack;
`ifdef MIPI_TX_ARB_STARVE_GUARD_EN
      starve = (m_wait >= LIMIT);
`else
      starve = 1'b0;
`endif
      if (pop) m_wait = 0;
      else if (qlen > 0 && m_owner != 2 && m_wait < LIMIT) m_wait++;
      if (m_owner == 0) begin
        if (starve && qlen > 0) m_owner = 2;
        else if (vid_req) m_owner = 1;
        else if (qlen > 0) m_owner = 2;
      end else if (m_pay) begin
        if (Tx_payload_en_last) begin
          m_owner = 0; m_pay = 1'b0;
        end
      end else if (m_owner == 1) begin
        if (!vid_req) m_owner = 0;
        else if (Tx_cmd_ack) begin
          if (vid_data_type >= 6'h10) m_pay = 1'b1;
          else m_owner = 0;
        end
      end else if (Tx_cmd_ack) begin
        if (m_q[0][21:16] >= 6'h10) m_pay = 1'b1;
        else m_owner = 0;
      end
      if (aux_wr && qlen == DEPTH && !pop) m_ovf = 1'b1;
      else if (aux_overflow_clr) m_ovf = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (aux_wr && (qlen < DEPTH || pop)) m_q.push_back({aux_wr_data_type, aux_wr_byte_count});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mipi_tx_cmd_arbiter.md
# mipi_tx_cmd_arbiter

Shares the single CSI-2 TX controller command port (data type, byte count, req/ack, payload strobes) between two requesters. The video requester is the line/frame timing generator. The auxiliary requester is a small internal queue of host-issued packets such as generic short packets or embedded/user long packets. The block sits between those sources and the TX core, holds a grant for a whole packet (header plus payload), and gives video priority at every packet boundary.

## Interface
Parameters:
- AUX_DEPTH, 4: aux command queue depth in entries; power of two, 2..16.
- STARVE_LIMIT, 16'd4096: CLK_tx cycles an aux entry may wait before it is forced in (used only with the macro).

Ports:
- CLK_tx  in  1  TX byte clock.
- RSTn  in  1  reset, asynchronous, active-low.
- vid_data_type  in  6  video packet data type.
- vid_byte_count  in  16  video word count.
- vid_req  in  1  video command request.
- vid_ack  out  1  video command accepted.
- vid_payload_en  out  1  payload strobe routed to video.
- vid_payload_en_last  out  1  last payload strobe routed to video.
- aux_wr  in  1  push one aux command.
- aux_wr_data_type  in  6  aux data type.
- aux_wr_byte_count  in  16  aux word count or short-packet data.
- aux_full  out  1  aux queue full.
- aux_payload_en  out  1  payload strobe routed to the aux data source.
- aux_payload_en_last  out  1  last aux payload strobe.
- aux_overflow  out  1  sticky flag: push attempted while full.
- aux_overflow_clr  in  1  clears aux_overflow.
- Tx_cmd_data_type  out  6  to TX core.
- Tx_cmd_byte_count  out  16  to TX core.
- Tx_cmd_req  out  1  to TX core.
- Tx_cmd_ack  in  1  from TX core.
- Tx_payload_en  in  1  from TX core.
- Tx_payload_en_last  in  1  from TX core.

## Operation
- The state register has five states: IDLE, HDR_V, HDR_A, PAY_V, PAY_A.
- IDLE:
  - vid_req=1 → HDR_V.
  - Otherwise, aux queue non-empty → HDR_A.
  - Video wins whenever both are pending, except under the starvation rule in Configuration.
- HDR_V: Tx_cmd_req = vid_req; fields are muxed from the vid_* inputs. vid_ack = Tx_cmd_ack.
  - On ack with data type ≥ 0x10 (long packet) → PAY_V.
  - On ack with a short packet → IDLE.
  - If vid_req drops before ack → IDLE. The TX core's request is withdrawn with no ack.
- HDR_A: Tx_cmd_req = 1; fields come from the queue head. On ack, pop the head. Long → PAY_A, short → IDLE.
- PAY_V / PAY_A:
  - Tx_payload_en and Tx_payload_en_last are routed only to the granted side; the other side's strobes stay 0.
  - Tx_payload_en_last=1 → IDLE.
  - Tx_cmd_req=0 throughout.
- Any new header is issued only from IDLE, so there is at least one idle cycle between packets.
- Aux queue:
  - A push while full is dropped and sets aux_overflow.
  - A simultaneous push and pop while full is accepted; the entry count stays unchanged.
  - aux_overflow_clr and a new overflow in the same cycle → flag stays 1.
- In IDLE, HDR_A and PAY_A, vid_ack=0.
- A long aux packet with byte count 0 still waits for Tx_payload_en_last.

## Timing
- Reset values:
  - State IDLE, queue empty, starve counter 0.
  - All outputs 0.
  - aux_full=0, aux_overflow=0.
- Request, ack and payload routing are combinational from the state register: zero-cycle pass-through.
- Arbitration latency: a request seen in IDLE at edge n drives Tx_cmd_req from cycle n+1.
- An aux push at edge n makes the queue non-empty at n+1; it can be granted at n+2 at the earliest.
- Reset mid-packet returns to IDLE immediately. The TX core and requesters are reset from the same RSTn.

## Configuration
- Macro: MIPI_TX_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments each cycle the aux queue is non-empty and the state is not HDR_A/PAY_A.
  - It clears on an aux pop and saturates at STARVE_LIMIT.
  - At the limit, the next IDLE selects HDR_A even if vid_req=1.
- Undefined: strict video priority; the counter is absent and aux can be starved indefinitely.

## Structure
- Package mipi_tx_pkg holds:
  - the state enum;
  - data-type constants: FS 0x00, FE 0x01, LS 0x02, LE 0x03, NULL 0x10, BLANK 0x11, RGB888 0x24, RAW 0x2A;
  - LONG_PKT_MIN = 6'h10;
  - a function is_long(dt).
- Sub-module aux_cmd_fifo: synchronous, 22-bit wide, AUX_DEPTH deep, first-word-fall-through head, full/empty flags.

## Test plan
- Video only: FS short packet (0x00, ack after 3 cycles), then 0x24 with count 0x0CA8. The TX core issues 3240 payload strobes then last → vid_ack pulses twice, strobes reach video only, state ends in IDLE.
- Aux only: push 0x10 count 6 → HDR_A, ack, PAY_A until last, queue empties, aux_full never asserts.
- Contention: vid_req held with 0x24 packets and aux holding one entry → video granted every boundary; aux is served only when vid_req drops.
- Overflow: 5 pushes into AUX_DEPTH=4 → 5th dropped, aux_overflow=1 until aux_overflow_clr, count stays 4.
- Withdrawal and reset: vid_req drops in HDR_V before ack → IDLE, no ack. RSTn low during PAY_V → all outputs 0 immediately.
- With MIPI_TX_ARB_STARVE_GUARD_EN and STARVE_LIMIT=16: vid_req continuous and one aux entry → aux header issued at the first IDLE after 16 waiting cycles.
